// File: rtl/alu_seq.sv
// Registered ALU: logic/arith ops complete in one cycle, shifts run 1 bit/cycle.
// Define ALU_ROTATE_EN to turn opcode 111 into an iterative rotate-left (otherwise PASS).
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   alu_cmd,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    input  logic         sc_i,
    output logic         out_valid,
    output logic [W-1:0] rslt,
    output logic         sc_o,
    output logic         pari,
    output logic         zero,
    output logic         o_dbg_state
);
    localparam int SW = $clog2(W);
    localparam logic [W-1:0] MAX_AMT = W'(W - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_PAR = 3'b101;
    localparam logic [2:0] OP_AND = 3'b110;
    localparam logic [2:0] OP_P7  = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_wk;
    logic [SW-1:0]  r_cnt;
    logic           r_left;

    state_t         w_state_nxt;
    logic [W-1:0]   w_wk_nxt;
    logic [SW-1:0]  w_cnt_nxt;
    logic           w_left_nxt;
    logic           w_upd;
    logic [W-1:0]   w_res;
    logic           w_c;
    logic           w_out_bit;
    logic           w_fill;

`ifdef ALU_ROTATE_EN
    logic           r_rot;
    logic           w_rot_nxt;
    assign w_fill = r_rot & r_wk[W-1];
`else
    assign w_fill = 1'b0;
`endif

    // Handshake: an op is taken on any edge where in_valid & in_ready; in_ready
    // is high only in IDLE. out_valid is a one-cycle pulse with no backpressure.
    assign in_ready    = (r_state == ST_IDLE);
    assign o_dbg_state = (r_state == ST_SHIFT);

    always_comb begin
        w_state_nxt = r_state;
        w_wk_nxt    = r_wk;
        w_cnt_nxt   = r_cnt;
        w_left_nxt  = r_left;
        w_upd       = 1'b0;
        w_res       = rslt;
        w_c         = sc_o;
        w_out_bit   = 1'b0;
`ifdef ALU_ROTATE_EN
        w_rot_nxt   = r_rot;
`endif
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_upd = 1'b1;
                    w_c   = 1'b0;
                    case (alu_cmd)
                        OP_ADD: {w_c, w_res} = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
                        OP_SUB: {w_c, w_res} = {1'b0, inA} + {1'b0, ~inB} + {{W{1'b0}}, sc_i};
                        OP_SHR, OP_SHL: begin
                            if (inB == '0) begin
                                w_res = inA;
                            end else if (inB > MAX_AMT) begin
                                w_res = '0;
                            end else begin
                                // Iterative path: flags stay untouched until the last step.
                                w_upd       = 1'b0;
                                w_res       = rslt;
                                w_c         = sc_o;
                                w_wk_nxt    = inA;
                                w_cnt_nxt   = inB[SW-1:0];
                                w_left_nxt  = (alu_cmd == OP_SHL);
                                w_state_nxt = ST_SHIFT;
`ifdef ALU_ROTATE_EN
                                w_rot_nxt   = 1'b0;
`endif
                            end
                        end
                        OP_XOR: w_res = inA ^ inB;
                        OP_PAR: w_res = {{(W-1){1'b0}}, ^{inA, inB}};
                        OP_AND: w_res = inA & inB;
                        OP_P7: begin
`ifdef ALU_ROTATE_EN
                            if (inB[SW-1:0] == '0) begin
                                w_res = inA;
                            end else begin
                                w_upd       = 1'b0;
                                w_res       = rslt;
                                w_c         = sc_o;
                                w_wk_nxt    = inA;
                                w_cnt_nxt   = inB[SW-1:0];
                                w_left_nxt  = 1'b1;
                                w_rot_nxt   = 1'b1;
                                w_state_nxt = ST_SHIFT;
                            end
`else
                            w_res = inA;
`endif
                        end
                        default: w_res = inA;
                    endcase
                end
            end
            ST_SHIFT: begin
                w_out_bit = r_left ? r_wk[W-1] : r_wk[0];
                w_wk_nxt  = r_left ? {r_wk[W-2:0], w_fill} : {1'b0, r_wk[W-1:1]};
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == SW'(1)) begin
                    w_upd       = 1'b1;
                    w_res       = w_wk_nxt;
                    w_c         = w_out_bit;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_wk      <= '0;
            r_cnt     <= '0;
            r_left    <= 1'b0;
            rslt      <= '0;
            sc_o      <= 1'b0;
            pari      <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wk      <= w_wk_nxt;
            r_cnt     <= w_cnt_nxt;
            r_left    <= w_left_nxt;
            out_valid <= w_upd;
            if (w_upd) begin
                rslt <= w_res;
                sc_o <= w_c;
                pari <= ^w_res;
                zero <= (w_res == '0);
            end
        end
    end

`ifdef ALU_ROTATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rot <= 1'b0;
        end else begin
            r_rot <= w_rot_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomized bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_cmd;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         sc_i;
  logic         out_valid;
  logic [W-1:0] rslt;
  logic         sc_o;
  logic         pari;
  logic         zero;
  logic         dbg_state;

  int total = 0;
  int bad = 0;

  alu_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .sc_i(sc_i),
    .out_valid(out_valid), .rslt(rslt), .sc_o(sc_o), .pari(pari), .zero(zero),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: result, carry and cycles-to-out_valid from the opcode rules.
  function automatic void model(input logic [2:0] cmd, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic ci,
                                output logic [W-1:0] r, output logic c, output int lat);
    int k;
    int s;
    int rr;
    k = int'(b);
    lat = 1;
    c = 1'b0;
    r = '0;
    case (cmd)
      3'd0: begin
        s = int'(a) + int'(b) + int'(ci);
        r = W'(s);
        c = (s >= (1 << W));
      end
      3'd1: begin
        s = int'(a) + ((1 << W) - 1 - int'(b)) + int'(ci);
        r = W'(s);
        c = (s >= (1 << W));
      end
      3'd2: begin
        if (k == 0) r = a;
        else if (k >= W) r = '0;
        else begin
          r = a >> k;
          c = a[k-1];
          lat = k + 1;
        end
      end
      3'd3: begin
        if (k == 0) r = a;
        else if (k >= W) r = '0;
        else begin
          r = W'(a << k);
          c = a[W-k];
          lat = k + 1;
        end
      end
      3'd4: r = a ^ b;
      3'd5: r = (^{a, b}) ? W'(1) : W'(0);
      3'd6: r = a & b;
      default: begin
`ifdef ALU_ROTATE_EN
        rr = k % W;
        if (rr == 0) r = a;
        else begin
          r = W'(a << rr) | W'(a >> (W - rr));
          c = r[0];
          lat = rr + 1;
        end
`else
        rr = 0;
        r = a;
`endif
      end
    endcase
  endfunction

  // driver: call at #1 after a rising edge with the DUT idle
  task automatic run_op(input logic [2:0] cmd, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci);
    logic [W-1:0] er;
    logic ec;
    int el;
    int lat;
    model(cmd, a, b, ci, er, ec, el);
    chk("ready_before", 32'(in_ready), 32'd1);
    alu_cmd = cmd; inA = a; inB = b; sc_i = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!out_valid && lat < 64) begin
      chk("busy_ready", 32'(in_ready), 32'd0);
      in_valid = 1'($urandom_range(0, 1));
      alu_cmd = 3'($urandom); inA = W'($urandom); inB = W'($urandom); sc_i = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(el));
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("rslt", 32'(rslt), 32'(er));
    chk("sc_o", 32'(sc_o), 32'(ec));
    chk("pari", 32'(pari), 32'(^er));
    chk("zero", 32'(zero), 32'(er == '0));
    @(posedge clk); #1;
    chk("pulse_end", 32'(out_valid), 32'd0);
  endtask

  // back-to-back check helper: results of the op accepted at the previous edge
  task automatic chk_now(input string tag, input logic [W-1:0] er);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_rslt"}, 32'(rslt), 32'(er));
    chk({tag, "_sc"}, 32'(sc_o), 32'd0);
  endtask

  initial begin
    logic [W-1:0] er;
    logic ec;
    int el;
    rst_n = 1'b0; in_valid = 1'b0; alu_cmd = '0; inA = '0; inB = '0; sc_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rslt", 32'(rslt), 32'd0);
    chk("rst_sc", 32'(sc_o), 32'd0);
    chk("rst_pari", 32'(pari), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors
    run_op(3'd0, 8'hF0, 8'h20, 1'b1);
    chk("add_vec", 32'(rslt), 32'h11);
    run_op(3'd1, 8'd5, 8'd3, 1'b1);
    chk("sub_vec1", 32'(rslt), 32'h02);
    run_op(3'd1, 8'd3, 8'd5, 1'b1);
    chk("sub_vec2", 32'(rslt), 32'hFE);
    run_op(3'd3, 8'h81, 8'd3, 1'b0);
    chk("shl_vec", 32'(rslt), 32'h08);
    run_op(3'd2, 8'h81, 8'd1, 1'b0);
    chk("shr_vec", 32'(rslt), 32'h40);
    run_op(3'd2, 8'h5A, 8'd0, 1'b0);
    run_op(3'd3, 8'h5A, 8'd9, 1'b0);
    run_op(3'd3, 8'hC3, 8'd7, 1'b0);
    run_op(3'd2, 8'hC3, 8'd7, 1'b1);
    run_op(3'd2, 8'hC3, 8'd8, 1'b0);
    run_op(3'd7, 8'h81, 8'd1, 1'b0);
`ifdef ALU_ROTATE_EN
    chk("rol_vec", 32'(rslt), 32'h03);
    run_op(3'd7, 8'h81, 8'd8, 1'b0);
    run_op(3'd7, 8'h96, 8'd13, 1'b0);
`else
    chk("pass_vec", 32'(rslt), 32'h81);
`endif

    // back-to-back single-cycle ops, one per cycle
    alu_cmd = 3'd4; inA = 8'hA5; inB = 8'h3C; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_now("b2b_xor", 8'h99);
    alu_cmd = 3'd6; inA = 8'hF3; inB = 8'h3E;
    @(posedge clk); #1;
    chk_now("b2b_and", 8'h32);
    alu_cmd = 3'd5; inA = 8'h01; inB = 8'h00;
    @(posedge clk); #1;
    chk_now("b2b_par", 8'h01);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // reset during the second SHIFT cycle of SHL by 5
    run_op(3'd0, 8'hF0, 8'h20, 1'b1);
    alu_cmd = 3'd3; inA = 8'h81; inB = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_busy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_rslt", 32'(rslt), 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end

    // randomized ops against the model
    for (int n = 0; n < 80; n++) begin
      logic [2:0] c;
      logic [W-1:0] b;
      c = 3'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, W + 1));
      run_op(c, W'($urandom), b, 1'($urandom));
    end

    model(3'd0, 8'hFF, 8'h00, 1'b1, er, ec, el);
    run_op(3'd0, 8'hFF, 8'h00, 1'b1);
    chk("add_wrap_zero", 32'(zero), 32'(er == '0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
